rgb_pack: RTL and testbench

RGB_PACK -- requirements
Module: rgb_pack

---
 rtl/rgb_pack_pkg.sv | 54 +++++
 rtl/rgb_pack_fifo.sv | 54 +++++
 rtl/rgb_pack.sv | 118 +++++++++++
 tb/tb_rgb_pack.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pack_pkg.sv
// rgb_pack_pkg: shared RGB565 field widths, rounding constants, pixel type
// and the conversion helper used by rgb_pack.
package rgb_pack_pkg;

  localparam int unsigned R_W = 5;
  localparam int unsigned G_W = 6;
  localparam int unsigned B_W = 5;

  // Half an LSB of each truncated field, added before the shift.
  localparam logic [7:0] RND_R = 8'd4;
  localparam logic [7:0] RND_G = 8'd2;
  localparam logic [7:0] RND_B = 8'd4;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } pixel_t;

  // What the staged pixel does on the coming edge.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PUSH = 2'd1,
    WR_DROP = 2'd2
  } wr_act_e;

  function automatic logic [7:0] sat8_add(input logic [7:0] v, input logic [7:0] k);
    logic [8:0] s;
    s = {1'b0, v} + {1'b0, k};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic pixel_t pack565(input logic [7:0] r, input logic [7:0] g,
                                     input logic [7:0] b, input bit rnd);
    pixel_t     p;
    logic [7:0] rr;
    logic [7:0] gg;
    logic [7:0] bb;
    if (rnd) begin
      rr = sat8_add(r, RND_R);
      gg = sat8_add(g, RND_G);
      bb = sat8_add(b, RND_B);
    end else begin
      rr = r;
      gg = g;
      bb = b;
    end
    p.r = rr[7 -: R_W];
    p.g = gg[7 -: G_W];
    p.b = bb[7 -: B_W];
    return p;
  endfunction

endpackage

// File: rtl/rgb_pack_fifo.sv
// rgb_pack_fifo: pixel FIFO with wrapping pointers and an occupancy counter.
// The head is forced to zero while empty so the output never shows stale data.
module rgb_pack_fifo
  import rgb_pack_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_wr_en,
  input  pixel_t i_wr_data,
  input  logic   i_rd_en,
  output logic   o_empty,
  output logic   o_full,
  output pixel_t o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pixel_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_rd    = i_rd_en & ~o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) r_wptr <= r_wptr + AW'(1);
      if (w_rd)    r_rptr <= r_rptr + AW'(1);
      case ({i_wr_en, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_pack.sv
// rgb_pack: packs aligned 8-bit R/G/B triples into RGB565 pixels through a
// one-stage conversion register and an output FIFO, with sticky overflow and
// alignment-error flags. Define RGB_PACK_DROP_CNT_EN to add the drop_cnt port.
module rgb_pack
  import rgb_pack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROUND      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r_val,
  input  logic [7:0]  r_data,
  input  logic        g_val,
  input  logic [7:0]  g_data,
  input  logic        b_val,
  input  logic [7:0]  b_data,
  output logic        px_val,
  output logic [15:0] px_data,
  input  logic        px_rdy,
  output logic        ovf,
  output logic        align_err,
  input  logic        clr_err
`ifdef RGB_PACK_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  logic    w_all_val;
  logic    w_any_val;
  logic    w_misalign;
  logic    r_stage_v;
  pixel_t  r_stage_px;
  logic    w_empty;
  logic    w_full;
  logic    w_pop;
  logic    w_push;
  logic    w_drop;
  wr_act_e w_wr_act;
  pixel_t  w_head;
  logic    r_ovf;
  logic    r_align_err;

  assign w_all_val  = r_val & g_val & b_val;
  assign w_any_val  = r_val | g_val | b_val;
  assign w_misalign = w_any_val & ~w_all_val;

  assign px_val    = ~w_empty;
  assign px_data   = w_head;
  assign w_pop     = px_val & px_rdy;
  assign ovf       = r_ovf;
  assign align_err = r_align_err;

  // Capture and convert an aligned triple; the stage is consumed every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage_v  <= 1'b0;
      r_stage_px <= '0;
    end else begin
      r_stage_v <= w_all_val;
      if (w_all_val) r_stage_px <= pack565(r_data, g_data, b_data, ROUND != 0);
    end
  end

  // A full FIFO still accepts the staged pixel when a pop frees a slot this edge.
  always_comb begin
    w_wr_act = WR_IDLE;
    if (r_stage_v) w_wr_act = (!w_full || w_pop) ? WR_PUSH : WR_DROP;
  end

  assign w_push = (w_wr_act == WR_PUSH);
  assign w_drop = (w_wr_act == WR_DROP);

  // Sticky error flags; a new error in the same cycle overrides clr_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf       <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_misalign)   r_align_err <= 1'b1;
      else if (clr_err) r_align_err <= 1'b0;
    end
  end

`ifdef RGB_PACK_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  // Saturating drop counter; a drop coinciding with clr_err counts as the first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (clr_err) begin
      r_drop_cnt <= w_drop ? 16'd1 : '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

  rgb_pack_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_wr_en  (w_push),
    .i_wr_data(r_stage_px),
    .i_rd_en  (w_pop),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_head   (w_head)
  );

endmodule

// File: tb/tb_rgb_pack.sv
// tb_rgb_pack: runs a rounding and a truncating rgb_pack side by side from the
// same stimulus and compares both against a queue-based pixel model.
module tb_rgb_pack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        r_val = 1'b0, g_val = 1'b0, b_val = 1'b0;
  logic [7:0]  r_data = '0, g_data = '0, b_data = '0;
  logic        px_rdy = 1'b0, clr_err = 1'b0;
  logic        pv_r, pv_t, ovf_r, ovf_t, al_r, al_t;
  logic [15:0] pd_r, pd_t;
`ifdef RGB_PACK_DROP_CNT_EN
  logic [15:0] dc_r, dc_t;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: raw triples in the FIFO, the staged triple, flags.
  logic [23:0] mq[$];
  bit          m_stv = 0;
  logic [23:0] m_st = '0;
  bit          m_ovf = 0, m_aln = 0;
  int          m_dcnt = 0;

  always #5 clk = ~clk;

  rgb_pack #(.FIFO_DEPTH(DEPTH), .ROUND(1)) u_rnd (
    .clk(clk), .reset_n(reset_n),
    .r_val(r_val), .r_data(r_data), .g_val(g_val), .g_data(g_data),
    .b_val(b_val), .b_data(b_data),
    .px_val(pv_r), .px_data(pd_r), .px_rdy(px_rdy),
    .ovf(ovf_r), .align_err(al_r), .clr_err(clr_err)
`ifdef RGB_PACK_DROP_CNT_EN
    , .drop_cnt(dc_r)
`endif
  );

  rgb_pack #(.FIFO_DEPTH(DEPTH), .ROUND(0)) u_trn (
    .clk(clk), .reset_n(reset_n),
    .r_val(r_val), .r_data(r_data), .g_val(g_val), .g_data(g_data),
    .b_val(b_val), .b_data(b_data),
    .px_val(pv_t), .px_data(pd_t), .px_rdy(px_rdy),
    .ovf(ovf_t), .align_err(al_t), .clr_err(clr_err)
`ifdef RGB_PACK_DROP_CNT_EN
    , .drop_cnt(dc_t)
`endif
  );

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // RGB565 from the arithmetic rules: optional round-and-clamp, then divide.
  function automatic logic [15:0] conv(input logic [23:0] raw, input bit rnd);
    int r, g, b;
    r = int'(raw[23:16]);
    g = int'(raw[15:8]);
    b = int'(raw[7:0]);
    if (rnd) begin
      r = sat(r + 4);
      g = sat(g + 2);
      b = sat(b + 4);
    end
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  function automatic logic [15:0] exp_data(input bit rnd);
    if (mq.size() == 0) return 16'h0000;
    return conv(mq[0], rnd);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_stv  = 0;
    m_ovf  = 0;
    m_aln  = 0;
    m_dcnt = 0;
  endfunction

  // Model of one rising edge, using the inputs the bench is driving.
  function automatic void model_edge();
    bit all1, mis, pop, room, drop;
    if (!reset_n) begin
      model_reset();
      return;
    end
    all1 = r_val && g_val && b_val;
    mis  = (r_val || g_val || b_val) && !all1;
    pop  = (mq.size() != 0) && px_rdy;
    room = (mq.size() < DEPTH) || pop;
    drop = 0;
    if (pop) void'(mq.pop_front());
    if (m_stv) begin
      if (room) mq.push_back(m_st);
      else drop = 1;
    end
    m_stv = all1;
    m_st  = {r_data, g_data, b_data};
    m_ovf = drop ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_aln = mis ? 1'b1 : (clr_err ? 1'b0 : m_aln);
    if (clr_err) m_dcnt = drop ? 1 : 0;
    else if (drop && m_dcnt < 65535) m_dcnt++;
  endfunction

  task automatic drive(input logic [2:0] vals, input logic [23:0] rgb,
                       input logic rdy, input logic clr);
    {r_val, g_val, b_val}    = vals;
    {r_data, g_data, b_data} = rgb;
    px_rdy  = rdy;
    clr_err = clr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ev;
    model_reset();
    drive(3'b000, 24'h0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    ev = (mq.size() != 0);
    n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL reset_px_val got %0b/%0b exp %0b", pv_r, pv_t, ev); end
    n_chk++; if (pd_r !== 16'h0 || pd_t !== 16'h0) begin n_fail++; $display("FAIL reset_px_data got %h/%h exp 0000", pd_r, pd_t); end
    n_chk++; if (ovf_r !== 1'b0 || ovf_t !== 1'b0 || al_r !== 1'b0 || al_t !== 1'b0) begin n_fail++; $display("FAIL reset_flags ovf %0b/%0b align %0b/%0b exp 0", ovf_r, ovf_t, al_r, al_t); end
    @(negedge clk);
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_conversion();
    logic [23:0] vec [6] = '{24'hFFFFFF, 24'h848204, 24'h0F0307, 24'hF8FCF8, 24'h000000, 24'hFDFEFB};
    bit ev;
    foreach (vec[k]) begin
      for (int c = 0; c < 3; c++) begin
        drive((c == 0) ? 3'b111 : 3'b000, vec[k], 1'b1, 1'b0);
        step();
        ev = (mq.size() != 0);
        n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL conv_px_val vec %h cyc %0d got %0b/%0b exp %0b", vec[k], c, pv_r, pv_t, ev); end
        n_chk++; if (pd_r !== exp_data(1) || pd_t !== exp_data(0)) begin n_fail++; $display("FAIL conv_px_data vec %h cyc %0d got %h/%h exp %h/%h", vec[k], c, pd_r, pd_t, exp_data(1), exp_data(0)); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ev;
    for (int c = 0; c < 14; c++) begin
      if (c < 6)       drive(3'b111, 24'($urandom), 1'b0, 1'b0);
      else if (c < 8)  drive(3'b000, 24'h0, 1'b0, 1'b0);
      else if (c < 13) drive(3'b000, 24'h0, 1'b1, 1'b0);
      else             drive(3'b000, 24'h0, 1'b1, 1'b1);
      step();
      ev = (mq.size() != 0);
      n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL bp_px_val cyc %0d got %0b/%0b exp %0b", c, pv_r, pv_t, ev); end
      n_chk++; if (pd_r !== exp_data(1) || pd_t !== exp_data(0)) begin n_fail++; $display("FAIL bp_px_data cyc %0d got %h/%h exp %h/%h", c, pd_r, pd_t, exp_data(1), exp_data(0)); end
      n_chk++; if (ovf_r !== m_ovf || ovf_t !== m_ovf) begin n_fail++; $display("FAIL bp_ovf cyc %0d got %0b/%0b exp %0b", c, ovf_r, ovf_t, m_ovf); end
`ifdef RGB_PACK_DROP_CNT_EN
      n_chk++; if (dc_r !== 16'(m_dcnt) || dc_t !== 16'(m_dcnt)) begin n_fail++; $display("FAIL bp_drop_cnt cyc %0d got %0d/%0d exp %0d", c, dc_r, dc_t, m_dcnt); end
`endif
    end
  endtask

  task automatic test_full_pop();
    bit ev;
    for (int c = 0; c < 16; c++) begin
      if (c < 5)       drive(3'b111, 24'($urandom), 1'b0, c == 0);
      else if (c < 11) drive(3'b111, 24'($urandom), 1'b1, 1'b0);
      else             drive(3'b000, 24'h0, 1'b1, 1'b0);
      step();
      ev = (mq.size() != 0);
      n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL fullpop_px_val cyc %0d got %0b/%0b exp %0b", c, pv_r, pv_t, ev); end
      n_chk++; if (pd_r !== exp_data(1) || pd_t !== exp_data(0)) begin n_fail++; $display("FAIL fullpop_px_data cyc %0d got %h/%h exp %h/%h", c, pd_r, pd_t, exp_data(1), exp_data(0)); end
      n_chk++; if (ovf_r !== m_ovf || ovf_t !== m_ovf) begin n_fail++; $display("FAIL fullpop_ovf cyc %0d got %0b/%0b exp %0b", c, ovf_r, ovf_t, m_ovf); end
    end
  endtask

  task automatic test_misalign();
    logic [2:0] pat [8] = '{3'b110, 3'b000, 3'b000, 3'b011, 3'b100, 3'b000, 3'b111, 3'b000};
    logic       clr [8] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
    bit ev;
    foreach (pat[k]) begin
      drive(pat[k], 24'($urandom), 1'b1, clr[k]);
      step();
      ev = (mq.size() != 0);
      n_chk++; if (al_r !== m_aln || al_t !== m_aln) begin n_fail++; $display("FAIL misalign_flag step %0d got %0b/%0b exp %0b", k, al_r, al_t, m_aln); end
      n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL misalign_px_val step %0d got %0b/%0b exp %0b", k, pv_r, pv_t, ev); end
    end
  endtask

  task automatic test_random();
    logic [2:0] v;
    bit ev;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) v = 3'($urandom);
      else v = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'b000;
      drive(v, 24'($urandom), ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            $urandom_range(0, 19) == 0);
      step();
      ev = (mq.size() != 0);
      n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL rand_px_val cyc %0d got %0b/%0b exp %0b", c, pv_r, pv_t, ev); end
      n_chk++; if (pd_r !== exp_data(1) || pd_t !== exp_data(0)) begin n_fail++; $display("FAIL rand_px_data cyc %0d got %h/%h exp %h/%h", c, pd_r, pd_t, exp_data(1), exp_data(0)); end
      n_chk++; if (ovf_r !== m_ovf || ovf_t !== m_ovf || al_r !== m_aln || al_t !== m_aln) begin n_fail++; $display("FAIL rand_flags cyc %0d ovf %0b/%0b align %0b/%0b exp %0b %0b", c, ovf_r, ovf_t, al_r, al_t, m_ovf, m_aln); end
`ifdef RGB_PACK_DROP_CNT_EN
      n_chk++; if (dc_r !== 16'(m_dcnt) || dc_t !== 16'(m_dcnt)) begin n_fail++; $display("FAIL rand_drop_cnt cyc %0d got %0d/%0d exp %0d", c, dc_r, dc_t, m_dcnt); end
`endif
    end
  endtask

  task automatic test_async_reset();
    bit ev;
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, 24'($urandom), 1'b0, 1'b0);
      step();
    end
    drive(3'b111, 24'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    model_edge();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if (pv_r !== 1'b0 || pv_t !== 1'b0) begin n_fail++; $display("FAIL arst_px_val got %0b/%0b exp 0", pv_r, pv_t); end
    n_chk++; if (pd_r !== 16'h0 || pd_t !== 16'h0) begin n_fail++; $display("FAIL arst_px_data got %h/%h exp 0000", pd_r, pd_t); end
    @(negedge clk);
    reset_n = 1'b1;
    drive(3'b000, 24'h0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      ev = (mq.size() != 0);
      n_chk++; if (pv_r !== ev || pv_t !== ev) begin n_fail++; $display("FAIL arst_after_px_val cyc %0d got %0b/%0b exp %0b", c, pv_r, pv_t, ev); end
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_backpressure();
    test_full_pop();
    test_misalign();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
